// File: rtl/zoom_stack_unit.sv
// zoom_stack_unit
//   Turns pointer-centred zoom-in / zoom-out / home button presses into a
//   stack of per-level view origins. Level L has a pixel step of
//   2^-(S0+L). The current view is offered to the renderer through a
//   valid/ready handshake and held stable until accepted.
//
// Ports
//   clk, rst_n           single clock, synchronous active-low reset
//   pixel_coord_X/Y      pointer position in pixels (unsigned)
//   zoom_in_btn          raw asynchronous button
//   zoom_out_btn         raw asynchronous button
//   home_btn             raw asynchronous button
//   upd_ready            renderer accepts the presented view
//   upd_valid            a new view is committed, held until accepted
//   origin_X/Y           top-left coordinate of the current level
//   step_shift           current step = 2^-step_shift (S0 + zoom_level)
//   zoom_level           current stack level
//   busy                 an operation is in progress (not idle)
module zoom_stack_unit #(
  parameter int Q      = 21,
  parameter int N      = 32,
  parameter int LEVELS = 8,
  parameter int LVL_W  = 3,
  parameter int S0     = 8,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter logic [N-1:0] HOME_X = 32'hFFC00000,
  parameter logic [N-1:0] HOME_Y = 32'h00258000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pixel_coord_X,
  input  logic [15:0]      pixel_coord_Y,
  input  logic             zoom_in_btn,
  input  logic             zoom_out_btn,
  input  logic             home_btn,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [N-1:0]     origin_X,
  output logic [N-1:0]     origin_Y,
  output logic [4:0]       step_shift,
  output logic [LVL_W-1:0] zoom_level,
  output logic             busy
);

  localparam int W = N + 2;
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(LEVELS - 1);
  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);
  localparam logic signed [W-1:0] SAT_MAX = W'({1'b0, {(N-1){1'b1}}});
  localparam logic signed [W-1:0] SAT_MIN = {{2{1'b1}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Clip an (N+2)-bit signed result into the N-bit signed range.
  function automatic logic [N-1:0] sat_n(input logic signed [W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[N-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[N-1:0];
    end else begin
      return v[N-1:0];
    end
  endfunction

  state_t state_r, state_nxt;

  // Button order in the vectors: [2]=home, [1]=out, [0]=in
  logic [2:0] sync1_r, sync2_r, prev_r, evt_r;
  logic       home_evt_s, in_evt_s, out_evt_s;
  logic       do_home_s, do_latch_s, do_out_s, do_calc_s;

  logic [N-1:0]     org_x_r [LEVELS];
  logic [N-1:0]     org_y_r [LEVELS];
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] lvl_up_s, lvl_dn_s;
  logic [15:0]      px_r, py_r;
  logic [N-1:0]     origin_x_r, origin_y_r;
  logic [4:0]       step_r;
  logic             upd_valid_r, busy_r;

  logic [4:0]          sh_s;
  logic signed [W-1:0] p_x_s, p_y_s, new_x_s, new_y_s;
  logic [N-1:0]        sat_x_s, sat_y_s;

  // Two-flop synchroniser plus registered rising-edge pulse per button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      prev_r  <= 3'b000;
      evt_r   <= 3'b000;
    end else begin
      sync1_r <= {home_btn, zoom_out_btn, zoom_in_btn};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      evt_r   <= sync2_r & ~prev_r;
    end
  end

  // Home wins outright; in and out together cancel each other.
  assign home_evt_s = evt_r[2];
  assign in_evt_s   = evt_r[0] & ~evt_r[1] & ~evt_r[2];
  assign out_evt_s  = evt_r[1] & ~evt_r[0] & ~evt_r[2];

  assign lvl_up_s = level_r + LVL_ONE;
  assign lvl_dn_s = level_r - LVL_ONE;

  // Next-centre arithmetic for zoom-in; sh is the log2 pixel step in LSBs.
  always_comb begin
    sh_s    = 5'(Q - S0) - 5'(level_r);
    p_x_s   = W'(signed'(org_x_r[level_r])) + (W'(px_r) << sh_s);
    p_y_s   = W'(signed'(org_y_r[level_r])) - (W'(py_r) << sh_s);
    new_x_s = p_x_s - (W'(H_RES / 2) << (sh_s - 5'd1));
    new_y_s = p_y_s + (W'(V_RES / 2) << (sh_s - 5'd1));
    sat_x_s = sat_n(new_x_s);
    sat_y_s = sat_n(new_y_s);
  end

  // FSM state register; valid/busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      upd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      upd_valid_r <= (state_nxt == WAIT_ACK);
      busy_r      <= (state_nxt != IDLE);
    end
  end

  // FSM next state and datapath strobes; events outside IDLE are dropped.
  always_comb begin
    state_nxt  = state_r;
    do_home_s  = 1'b0;
    do_latch_s = 1'b0;
    do_out_s   = 1'b0;
    do_calc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (home_evt_s) begin
          do_home_s = 1'b1;
          state_nxt = WAIT_ACK;
        end else if (in_evt_s && (level_r != LVL_MAX)) begin
          do_latch_s = 1'b1;
          state_nxt  = CALC;
        end else if (out_evt_s && (level_r != LVL_ZERO)) begin
          do_out_s  = 1'b1;
          state_nxt = WAIT_ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        do_calc_s = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (upd_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_ACK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Origin stack, level and registered view outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LEVELS; i++) begin
        org_x_r[i] <= HOME_X;
        org_y_r[i] <= HOME_Y;
      end
      level_r    <= LVL_ZERO;
      px_r       <= 16'd0;
      py_r       <= 16'd0;
      origin_x_r <= HOME_X;
      origin_y_r <= HOME_Y;
      step_r     <= 5'(S0);
    end else if (do_home_s) begin
      org_x_r[0] <= HOME_X;
      org_y_r[0] <= HOME_Y;
      level_r    <= LVL_ZERO;
      origin_x_r <= HOME_X;
      origin_y_r <= HOME_Y;
      step_r     <= 5'(S0);
    end else if (do_latch_s) begin
      px_r <= (pixel_coord_X > X_MAX) ? X_MAX : pixel_coord_X;
      py_r <= (pixel_coord_Y > Y_MAX) ? Y_MAX : pixel_coord_Y;
    end else if (do_out_s) begin
      // Lower entries are never touched by zoom-in above them: exact restore.
      level_r    <= lvl_dn_s;
      origin_x_r <= org_x_r[lvl_dn_s];
      origin_y_r <= org_y_r[lvl_dn_s];
      step_r     <= 5'(S0) + 5'(lvl_dn_s);
    end else if (do_calc_s) begin
      org_x_r[lvl_up_s] <= sat_x_s;
      org_y_r[lvl_up_s] <= sat_y_s;
      level_r           <= lvl_up_s;
      origin_x_r        <= sat_x_s;
      origin_y_r        <= sat_y_s;
      step_r            <= 5'(S0) + 5'(lvl_up_s);
    end else begin
      level_r <= level_r;
    end
  end

  assign upd_valid  = upd_valid_r;
  assign busy       = busy_r;
  assign origin_X   = origin_x_r;
  assign origin_Y   = origin_y_r;
  assign step_shift = step_r;
  assign zoom_level = level_r;

endmodule
